// File: rtl/cpu_param.sv
// ============================================================================
// cpu_param
// ----------------------------------------------------------------------------
// Parametrised multi-cycle three-address processor core. An internal
// single-port word memory holds both program and data. Each instruction
// passes through six one-cycle states:
//     FETCH -> LDIR -> RDA -> RDB -> LDB -> EXE
// An external loader can write the memory while the core is held.
//
// Instruction word (DW = 2 + 3*AW bits):
//     [DW-1:DW-2]  op   00 ADD, 01 SUB, 10 OUT, 11 BEQ/NOP
//     next AW bits a    first source address
//     next AW bits b    second source address
//     low  AW bits c    destination address / branch target
//
// Build option:
//     CPU_PARAM_BRANCH_EN  defined   : opcode 11 is BEQ (pc <= c if mem[a]==mem[b])
//                          undefined : opcode 11 is a six-cycle NOP, and no
//                                      comparator is built
//
// Parameters:
//     AW        address width, memory depth is 2**AW words
//     RESET_PC  pc value after reset and after any program load
//     DW        derived data / instruction width (2 + 3*AW)
//
// Ports:
//     clk         in   single clock, everything on the rising edge
//     rst         in   synchronous active-high reset, wins over load_en
//     load_en     in   program-load write strobe, holds the core at FETCH
//     load_addr   in   load write address
//     load_data   in   load write data
//     Outp        out  output register, written by OUT
//     outp_valid  out  one-cycle pulse in the cycle after an OUT executes
//     pc          out  current program counter
//     busy        out  high whenever the core is not held by rst/load_en
// ============================================================================
module cpu_param #(
    parameter  int            AW       = 4,
    parameter  logic [AW-1:0] RESET_PC = '0,
    localparam int            DW       = 2 + 3 * AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    output logic [DW-1:0] Outp,
    output logic          outp_valid,
    output logic [AW-1:0] pc,
    output logic          busy
);

    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_OUT = 2'b10;
    localparam logic [1:0] OP_BEQ = 2'b11;

    localparam logic [AW-1:0] PC_STEP = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_LDIR  = 3'd1,
        S_RDA   = 3'd2,
        S_RDB   = 3'd3,
        S_LDB   = 3'd4,
        S_EXE   = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_ir;
    logic [DW-1:0] r_op1;
    logic [DW-1:0] r_op2;
    logic [DW-1:0] r_outp;
    logic          r_outpValid;
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_memQ;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    state_t        w_stateNext;
    logic [1:0]    w_op;
    logic [AW-1:0] w_fieldA;
    logic [AW-1:0] w_fieldB;
    logic [AW-1:0] w_fieldC;
    logic [DW-1:0] w_aluResult;
    logic [AW-1:0] w_memAddr;
    logic          w_memWe;
    logic [DW-1:0] w_memWdata;
    logic          w_branchTaken;
    logic          w_hold;

    // Instruction field decode from the latched instruction register.
    assign w_op     = r_ir[DW-1 -: 2];
    assign w_fieldA = r_ir[3*AW-1 -: AW];
    assign w_fieldB = r_ir[2*AW-1 -: AW];
    assign w_fieldC = r_ir[AW-1:0];

    // The core is frozen at FETCH whenever reset or the loader owns it.
    assign w_hold = rst | load_en;

    // Add/subtract share one result path; wrap-around is modulo 2**DW and
    // carry/borrow is simply dropped.
    assign w_aluResult = (w_op == OP_SUB) ? (r_op1 - r_op2) : (r_op1 + r_op2);

    // The equality comparator only exists when branching is built in; without
    // it opcode 11 falls through the EXE state as a plain NOP.
`ifdef CPU_PARAM_BRANCH_EN
    assign w_branchTaken = (w_op == OP_BEQ) && (r_op1 == r_op2);
`else
    assign w_branchTaken = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state and memory-port control. The memory has one address, so this
    // block picks which address the port sees in every state and whether the
    // cycle writes. Reset blocks every write; a load takes over the port and
    // forces the sequence back to FETCH, which also drops any half-finished
    // instruction before its EXE write.
    // ------------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        w_memAddr   = r_pc;
        w_memWe     = 1'b0;
        w_memWdata  = w_aluResult;

        if (rst) begin
            w_stateNext = S_FETCH;
        end else if (load_en) begin
            w_stateNext = S_FETCH;
            w_memAddr   = load_addr;
            w_memWe     = 1'b1;
            w_memWdata  = load_data;
        end else begin
            case (r_state)
                S_FETCH: begin
                    w_memAddr   = r_pc;
                    w_stateNext = S_LDIR;
                end
                S_LDIR: begin
                    w_stateNext = S_RDA;
                end
                S_RDA: begin
                    w_memAddr   = w_fieldA;
                    w_stateNext = S_RDB;
                end
                S_RDB: begin
                    w_memAddr   = w_fieldB;
                    w_stateNext = S_LDB;
                end
                S_LDB: begin
                    w_stateNext = S_EXE;
                end
                S_EXE: begin
                    w_memAddr   = w_fieldC;
                    w_stateNext = S_FETCH;
                    case (w_op)
                        OP_ADD,
                        OP_SUB:  w_memWe = 1'b1;
                        OP_OUT,
                        OP_BEQ:  w_memWe = 1'b0;
                        default: w_memWe = 1'b0;
                    endcase
                end
                default: begin
                    w_stateNext = S_FETCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Word memory: synchronous write, registered read data one cycle after the
    // address. Deliberately no reset so a program survives rst.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            r_mem[w_memAddr] <= w_memWdata;
        end
        r_memQ <= r_mem[w_memAddr];
    end

    // ------------------------------------------------------------------------
    // State register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers. LDIR captures the instruction and advances pc; the
    // operand registers pick up the read data in the cycle after each operand
    // address was presented. In EXE a taken branch overwrites the pc value
    // already advanced in LDIR, and OUT copies op1 to the output register.
    // During a load nothing here changes except pc returning to RESET_PC.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_outp      <= '0;
            r_outpValid <= 1'b0;
        end else begin
            r_outpValid <= 1'b0;
            if (load_en) begin
                r_pc <= RESET_PC;
            end else begin
                case (r_state)
                    S_LDIR: begin
                        r_ir <= r_memQ;
                        r_pc <= r_pc + PC_STEP;
                    end
                    S_RDB: begin
                        r_op1 <= r_memQ;
                    end
                    S_LDB: begin
                        r_op2 <= r_memQ;
                    end
                    S_EXE: begin
                        if (w_op == OP_OUT) begin
                            r_outp      <= r_op1;
                            r_outpValid <= 1'b1;
                        end
                        if (w_branchTaken) begin
                            r_pc <= w_fieldC;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign Outp       = r_outp;
    assign outp_valid = r_outpValid;
    assign pc         = r_pc;
    assign busy       = ~w_hold;

endmodule
